led_adder_ctrl: RTL and testbench

LED_ADDER_CTRL -- requirements
Module: led_adder_ctrl

---
 rtl/led_adder_pkg.sv | 14 +
 rtl/switch_debounce.sv | 46 ++++
 rtl/led_adder_ctrl.sv | 128 ++++++++++++
 tb/tb_led_adder_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/led_adder_pkg.sv
// Shared types and widths for the switch-driven 2+2 adder LED controller.
package led_adder_pkg;
    localparam int OPERAND_W = 2;
    localparam int SUM_W     = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        LOAD    = 3'd2,
        CAPTURE = 3'd3,
        BLANK   = 3'd4,
        SHOW    = 3'd5
    } state_t;
endpackage

// File: rtl/switch_debounce.sv
// One raw switch: 2-flop synchroniser then debounce; output follows after the
// synchronised level has differed for DEBOUNCE_CYCLES consecutive cycles. No backpressure.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic db_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the levels agree restarts the run of differing cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o = db_q;
endmodule

// File: rtl/led_adder_ctrl.sv
// Debounces four switches, commits a stable operand pair to an external adder and
// shows the sum on LEDs after a blanking gap; 3+BLANK_CYCLES cycles from commit to display.
module led_adder_ctrl
    import led_adder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SETTLE_CYCLES   = 25000,
    parameter int BLANK_CYCLES    = 2500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw1,
    input  logic                 sw2,
    input  logic                 sw3,
    input  logic                 sw4,
    output logic [OPERAND_W-1:0] add_a,
    output logic [OPERAND_W-1:0] add_b,
    input  logic [SUM_W-1:0]     add_sum,
    output logic                 LED_1,
    output logic                 LED_2,
    output logic                 LED_3,
    output logic                 busy
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST  = BW'(BLANK_CYCLES - 1);

    logic [3:0] raw_sw, deb_vec;
    assign raw_sw = {sw4, sw3, sw2, sw1};

    for (genvar i = 0; i < 4; i++) begin : g_db
        switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .sw_i  (raw_sw[i]),
            .db_o  (deb_vec[i])
        );
    end

    state_t               state_q, state_d;
    logic [3:0]           committed_q, committed_d;
    logic [3:0]           snap_q, snap_d;
    logic [OPERAND_W-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic [SUM_W-1:0]     result_q, result_d;
    logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
    logic [BW-1:0]        blank_cnt_q, blank_cnt_d;

    always_comb begin
        state_d      = state_q;
        committed_d  = committed_q;
        snap_d       = snap_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        result_d     = result_q;
        settle_cnt_d = settle_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        case (state_q)
            IDLE: begin
                if (deb_vec != committed_q) begin
                    state_d      = SETTLE;
                    snap_d       = deb_vec;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                // snap_q is the candidate being timed; a new candidate restarts the count.
                if (deb_vec == committed_q) begin
                    state_d = IDLE;
                end else if (deb_vec != snap_q) begin
                    snap_d       = deb_vec;
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = LOAD;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            LOAD: begin
                committed_d = deb_vec;
                add_a_d     = deb_vec[1:0];
                add_b_d     = deb_vec[3:2];
                state_d     = CAPTURE;
            end
            CAPTURE: begin
                result_d    = add_sum;
                blank_cnt_d = '0;
                state_d     = BLANK;
            end
            BLANK: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            SHOW:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            committed_q  <= '0;
            snap_q       <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            result_q     <= '0;
            settle_cnt_q <= '0;
            blank_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            committed_q  <= committed_d;
            snap_q       <= snap_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            result_q     <= result_d;
            settle_cnt_q <= settle_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
        end
    end

    assign add_a = add_a_q;
    assign add_b = add_b_q;
    assign {LED_1, LED_2, LED_3} = (state_q == BLANK) ? 3'b000 : result_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_led_adder_ctrl.sv
// Directed bench for led_adder_ctrl with small timing parameters and a behavioural adder.
module tb_led_adder_ctrl;
    import led_adder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw1, sw2, sw3, sw4;
    logic [1:0] add_a, add_b;
    logic [2:0] add_sum;
    logic       LED_1, LED_2, LED_3, busy;
    logic [2:0] leds;

    always #5 clk = ~clk;

    led_adder_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SETTLE_CYCLES  (3),
        .BLANK_CYCLES   (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw1     (sw1),
        .sw2     (sw2),
        .sw3     (sw3),
        .sw4     (sw4),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum),
        .LED_1   (LED_1),
        .LED_2   (LED_2),
        .LED_3   (LED_3),
        .busy    (busy)
    );

    assign add_sum = {1'b0, add_a} + {1'b0, add_b};
    assign leds    = {LED_1, LED_2, LED_3};

    int checks = 0;
    int errors = 0;
    int loads  = 0;

    always @(posedge clk) if (dut.state_q == LOAD) loads++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_sw(input logic [3:0] v);
        {sw4, sw3, sw2, sw1} = v;
    endtask

    task automatic run_seq(output int busy_len, output int blank_len, output int blank_bad,
                           output logic [2:0] show_led, output int timed_out);
        int n;
        busy_len = 0; blank_len = 0; blank_bad = 0; show_led = '0; timed_out = 0; n = 0;
        while (!busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!busy) timed_out = 1;
        n = 0;
        while (busy && n < 60) begin
            busy_len++;
            if (dut.state_q == BLANK) begin
                blank_len++;
                if (leds != 3'b000) blank_bad++;
            end
            if (dut.state_q == SHOW) show_led = leds;
            @(negedge clk);
            n++;
        end
        if (busy) timed_out = 1;
    endtask

    task automatic wait_blank(output int timed_out);
        int n;
        n = 0;
        while (dut.state_q != BLANK && n < 60) begin
            @(negedge clk);
            n++;
        end
        timed_out = (dut.state_q != BLANK) ? 1 : 0;
    endtask

    int         blen, bklen, bkbad, to, busy_seen;
    logic [2:0] shown;

    initial begin
        rst_n = 1'b0;
        set_sw(4'b0000);
        repeat (3) @(negedge clk);
        check("rst_leds", leds, 3'b000);
        check("rst_busy", busy, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_leds", leds, 3'b000);
        check("idle_state", dut.state_q, IDLE);

        // A=3, B=2
        set_sw(4'b1011);
        run_seq(blen, bklen, bkbad, shown, to);
        check("s1_timeout", to, 0);
        check("s1_busy_len", blen, 11);
        check("s1_blank_len", bklen, 5);
        check("s1_blank_bad", bkbad, 0);
        check("s1_show", shown, 3'b101);
        check("s1_leds", leds, 3'b101);
        check("s1_add_a", add_a, 3);
        check("s1_add_b", add_b, 2);
        check("s1_loads", loads, 1);

        // two-cycle glitch on sw1
        set_sw(4'b1010);
        repeat (2) @(negedge clk);
        set_sw(4'b1011);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("gl_busy", busy_seen, 0);
        check("gl_deb", dut.deb_vec, 4'b1011);
        check("gl_leds", leds, 3'b101);
        check("gl_loads", loads, 1);

        // B moves 2 -> 3 -> 1 while settling; only B=1 should load
        set_sw(4'b1111);
        repeat (2) @(negedge clk);
        set_sw(4'b0111);
        run_seq(blen, bklen, bkbad, shown, to);
        check("st_timeout", to, 0);
        check("st_busy_len", blen, 13);
        check("st_show", shown, 3'b100);
        check("st_add_b", add_b, 1);
        check("st_loads", loads, 2);

        // A=1,B=1 then switch to A=2,B=3 during blanking
        set_sw(4'b0101);
        wait_blank(to);
        check("bk_wait", to, 0);
        set_sw(4'b1110);
        run_seq(blen, bklen, bkbad, shown, to);
        check("bk1_show", shown, 3'b010);
        run_seq(blen, bklen, bkbad, shown, to);
        check("bk2_timeout", to, 0);
        check("bk2_busy_len", blen, 11);
        check("bk2_show", shown, 3'b101);
        check("bk2_leds", leds, 3'b101);
        check("bk2_add_a", add_a, 2);
        check("bk2_loads", loads, 4);

        // reset in the middle of blanking for A=3,B=3
        set_sw(4'b1111);
        wait_blank(to);
        check("rb_wait", to, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rb_leds", leds, 3'b000);
        check("rb_busy", busy, 0);
        check("rb_state", dut.state_q, IDLE);
        check("rb_add_a", add_a, 0);
        check("rb_deb", dut.deb_vec, 4'b0000);
        rst_n = 1'b1;
        run_seq(blen, bklen, bkbad, shown, to);
        check("rb_timeout", to, 0);
        check("rb_busy_len", blen, 11);
        check("rb_show", shown, 3'b110);
        check("rb_add_a2", add_a, 3);
        check("rb_add_b2", add_b, 3);
        check("rb_loads", loads, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
